// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
// Instruction fields, ALU operation codes, FSM states and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EXE, S_MEM, S_WB, S_TRAP
    } stateT;

    // NOP is the idle class held between reset and the first decode
    typedef enum logic [2:0] {
        C_NOP, C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_MUL, C_ILLEGAL
    } instrClassT;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder; its result is only meaningful
// while the controller is in ID.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output instrClassT  instrClass,
    output logic [2:0]  aluOp,
    output logic        illegal
);

    always_comb begin
        instrClass = C_ILLEGAL;
        aluOp      = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADD) begin
                    instrClass = C_ALU_R;
                end else if (funct == FN_SUB) begin
                    instrClass = C_ALU_R;
                    aluOp      = ALU_SUB;
                end
            end
            OP_ADDI: instrClass = C_ALU_I;
            OP_LW:   instrClass = C_LOAD;
            OP_SW:   instrClass = C_STORE;
            OP_MUL: begin
                instrClass = C_MUL;
                aluOp      = ALU_MUL;
            end
            default: instrClass = C_ILLEGAL;
        endcase
        illegal = (instrClass == C_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer with mul/mem handshakes and
// sticky trap on illegal encodings or handshake timeouts.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_TIMEOUT = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mul_done,
    input  logic       mem_ready,
    output logic       PCWre,
    output logic       IRWre,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       RegWre,
    output logic       RegDst,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] ALUOp,
    output logic       mul_start,
    output logic       trap,
    output logic       busy
);

    // The last permitted wait cycle is TIMEOUT-1 because the entry cycle is count 0
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

    stateT            state;
    instrClassT       cls;
    logic [2:0]       aluOpQ;
    logic [CNT_W-1:0] waitCnt;

    instrClassT decClass;
    logic [2:0] decAluOp;
    logic       decIllegal;

    ctrl_decode uDecode (
        .opcode     (opcode),
        .funct      (funct),
        .instrClass (decClass),
        .aluOp      (decAluOp),
        .illegal    (decIllegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IF;
            cls     <= C_NOP;
            aluOpQ  <= ALU_ADD;
            waitCnt <= '0;
        end else begin
            case (state)
                S_IF: if (run) state <= S_ID;
                S_ID: begin
                    cls     <= decClass;
                    aluOpQ  <= decAluOp;
                    waitCnt <= '0;
                    state   <= decIllegal ? S_TRAP : S_EXE;
                end
                S_EXE: begin
                    if (cls == C_MUL) begin
                        if (mul_done)               state   <= S_WB;
                        else if (waitCnt == MUL_LAST) state <= S_TRAP;
                        else                        waitCnt <= waitCnt + 1'b1;
                    end else if (cls == C_LOAD || cls == C_STORE) begin
                        waitCnt <= '0;
                        state   <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready)                state   <= (cls == C_LOAD) ? S_WB : S_IF;
                    else if (waitCnt == MEM_LAST) state   <= S_TRAP;
                    else                          waitCnt <= waitCnt + 1'b1;
                end
                S_WB:    state <= S_IF;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Strobes follow registered state/class; only IRWre and the sw PCWre see inputs
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcB   = 1'b0;
        DBDataSrc = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUOp     = 3'b000;
        mul_start = 1'b0;
        trap      = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            busy = (state != S_IF);
            if (state inside {S_EXE, S_MEM, S_WB}) begin
                ALUOp   = aluOpQ;
                ALUSrcB = cls inside {C_ALU_I, C_LOAD, C_STORE};
            end
            case (state)
                S_IF:  IRWre = run;
                S_EXE: mul_start = (cls == C_MUL) && (waitCnt == '0);
                S_MEM: begin
                    mRD   = (cls == C_LOAD);
                    mWR   = (cls == C_STORE);
                    PCWre = (cls == C_STORE) && mem_ready;
                end
                S_WB: begin
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                    RegDst    = cls inside {C_ALU_R, C_MUL};
                    DBDataSrc = (cls == C_LOAD);
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: outputs packed as
// {PCWre,IRWre,ALUSrcB,DBDataSrc, RegWre,RegDst,mRD,mWR, ALUOp, mul_start,trap,busy}.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, mul_done, mem_ready;
    logic [5:0] opcode, funct;
    logic       PCWre, IRWre, ALUSrcB, DBDataSrc, RegWre, RegDst, mRD, mWR;
    logic [2:0] ALUOp;
    logic       mul_start, trap, busy;
    logic [13:0] outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign outs = {PCWre, IRWre, ALUSrcB, DBDataSrc, RegWre, RegDst, mRD, mWR,
                   ALUOp, mul_start, trap, busy};

    multicycle_ctrl #(.MUL_TIMEOUT(32), .MEM_TIMEOUT(16), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .mul_done(mul_done), .mem_ready(mem_ready),
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .RegWre(RegWre), .RegDst(RegDst), .mRD(mRD), .mWR(mWR), .ALUOp(ALUOp),
        .mul_start(mul_start), .trap(trap), .busy(busy)
    );

    localparam logic [13:0] O_ZERO   = 14'b0000_0000_000_000;
    localparam logic [13:0] O_FETCH  = 14'b0100_0000_000_000;
    localparam logic [13:0] O_BUSY   = 14'b0000_0000_000_001;
    localparam logic [13:0] O_TRAP   = 14'b0000_0000_000_011;
    localparam logic [13:0] O_IMMEXE = 14'b0010_0000_000_001;
    localparam logic [13:0] O_LWMEM  = 14'b0010_0010_000_001;
    localparam logic [13:0] O_LWWB   = 14'b1011_1000_000_001;
    localparam logic [13:0] O_MULWT  = 14'b0000_0000_111_001;

    // advance to the next cycle, drive its inputs, let the outputs settle
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic md, input logic mr);
        @(posedge clk);
        #1;
        run = r; opcode = op; funct = fn; mul_done = md; mem_ready = mr;
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] exp);
        checks++;
        assert (outs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; opcode = '0; funct = '0; mul_done = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset_outs", O_ZERO);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("if_idle", O_ZERO);

        // add then sub
        cyc(1, 6'h00, 6'h20, 0, 0); chk("add_if", O_FETCH);
        cyc(0, 6'h00, 6'h20, 0, 0); chk("add_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);         chk("add_exe", O_BUSY);
        cyc(0, 0, 0, 0, 0);         chk("add_wb", 14'b1000_1100_000_001);
        cyc(1, 6'h00, 6'h22, 0, 0); chk("sub_if", O_FETCH);
        cyc(0, 6'h00, 6'h22, 0, 0); chk("sub_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);         chk("sub_exe", 14'b0000_0000_001_001);
        cyc(0, 0, 0, 0, 0);         chk("sub_wb", 14'b1000_1100_001_001);
        cyc(0, 0, 0, 0, 0);         chk("sub_done", O_ZERO);

        // lw with three extra mem waits
        cyc(1, 6'h23, 0, 0, 0); chk("lw_if", O_FETCH);
        cyc(0, 6'h23, 0, 0, 0); chk("lw_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);     chk("lw_exe", O_IMMEXE);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0); chk("lw_mem_wait", O_LWMEM);
        end
        cyc(0, 0, 0, 0, 1);     chk("lw_mem_rdy", O_LWMEM);
        cyc(0, 0, 0, 0, 0);     chk("lw_wb", O_LWWB);
        cyc(0, 0, 0, 0, 0);     chk("lw_done", O_ZERO);

        // sw with immediate mem_ready
        cyc(1, 6'h2B, 0, 0, 0); chk("sw_if", O_FETCH);
        cyc(0, 6'h2B, 0, 0, 0); chk("sw_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);     chk("sw_exe", O_IMMEXE);
        cyc(0, 0, 0, 0, 1);     chk("sw_mem", 14'b1010_0001_000_001);
        cyc(0, 0, 0, 0, 0);     chk("sw_done", O_ZERO);

        // lw with mem_ready arriving on the final allowed MEM cycle
        cyc(1, 6'h23, 0, 0, 0);
        cyc(0, 6'h23, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);     chk("lw_edge_mem16", O_LWMEM);
        cyc(0, 0, 0, 0, 0);     chk("lw_edge_wb", O_LWWB);
        cyc(0, 0, 0, 0, 0);     chk("lw_edge_done", O_ZERO);

        // mul, done on the fifth EXE cycle
        cyc(1, 6'h1C, 6'h02, 0, 0); chk("mul_if", O_FETCH);
        cyc(0, 6'h1C, 6'h02, 0, 0); chk("mul_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);         chk("mul_start", 14'b0000_0000_111_101);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0); chk("mul_wait", O_MULWT);
        end
        cyc(0, 0, 0, 1, 0);         chk("mul_done", O_MULWT);
        cyc(0, 0, 0, 0, 0);         chk("mul_wb", 14'b1000_1100_111_001);
        cyc(0, 0, 0, 0, 0);         chk("mul_ret", O_ZERO);

        // mul that never completes: 32 EXE cycles then TRAP
        cyc(1, 6'h1C, 0, 0, 0);
        cyc(0, 6'h1C, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);         chk("mto_start", 14'b0000_0000_111_101);
        for (int i = 0; i < 31; i++) cyc(0, 0, 0, 0, 0);
        chk("mto_exe32", O_MULWT);
        cyc(0, 0, 0, 0, 0);         chk("mto_trap", O_TRAP);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1);
        chk("mto_sticky", O_TRAP);
        cyc(1, 0, 0, 0, 0);
        reset = 1'b1; #1;           chk("mto_in_reset", O_ZERO);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0; #1;           chk("mto_after_reset", O_ZERO);

        // illegal opcode traps from ID
        cyc(1, 6'h3F, 0, 0, 0); chk("ill_if", O_FETCH);
        cyc(0, 6'h3F, 0, 0, 0); chk("ill_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);     chk("ill_trap", O_TRAP);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1; #1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0; #1;

        // R-type with unsupported funct also traps
        cyc(1, 6'h00, 6'h24, 0, 0);
        cyc(0, 6'h00, 6'h24, 0, 0);
        cyc(0, 0, 0, 0, 0);     chk("badfn_trap", O_TRAP);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1; #1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0; #1;

        // reset mid-MEM aborts the load
        cyc(1, 6'h23, 0, 0, 0);
        cyc(0, 6'h23, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);     chk("rmem_mem", O_LWMEM);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1; #1;       chk("rmem_in_reset", O_ZERO);
        cyc(0, 0, 0, 0, 1);
        reset = 1'b0; #1;       chk("rmem_idle", O_ZERO);
        cyc(1, 6'h00, 6'h20, 0, 0); chk("rmem_resume_if", O_FETCH);
        cyc(0, 6'h00, 6'h20, 0, 0); chk("rmem_resume_id", O_BUSY);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);         chk("rmem_resume_wb", 14'b1000_1100_000_001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
